// File: rtl/instr_fetch_pkg.sv
// Shared encodings for the instruction fetch unit: addressing modes, special
// registers, opcode format decode and fetch-sequencer states.
package instr_fetch_pkg;

   localparam logic [15:0] DEF_RESET_VEC = 16'hFFFE;

   localparam logic [1:0] AS_REG = 2'b00;
   localparam logic [1:0] AS_IDX = 2'b01;
   localparam logic [1:0] AS_IND = 2'b10;
   localparam logic [1:0] AS_INC = 2'b11;

   localparam logic [3:0] REG_PC = 4'd0;
   localparam logic [3:0] REG_SR = 4'd2;
   localparam logic [3:0] REG_CG = 4'd3;

   localparam logic [2:0] OP_JUMP = 3'b001;
   localparam logic [5:0] OP_FMT2 = 6'b000100;

   typedef enum logic [2:0] {
      S_VEC  = 3'd0,
      S_OP   = 3'd1,
      S_EXT1 = 3'd2,
      S_EXT2 = 3'd3,
      S_HOLD = 3'd4
   } ifu_state_t;

   typedef enum logic [1:0] {
      FMT_NONE = 2'd0,
      FMT_I    = 2'd1,
      FMT_II   = 2'd2,
      FMT_JUMP = 2'd3
   } ifu_fmt_t;

   function automatic ifu_fmt_t ifu_fmt(input logic [15:0] w);
      ifu_fmt_t f;
      if (w[15:12] >= 4'h4) begin
         f = FMT_I;
      end else if (w[15:13] == OP_JUMP) begin
         f = FMT_JUMP;
      end else if (w[15:10] == OP_FMT2) begin
         f = FMT_II;
      end else begin
         f = FMT_NONE;
      end
      return f;
   endfunction

   // Instruction words live on even addresses only.
   function automatic logic [15:0] word_align(input logic [15:0] a);
      return a & 16'hFFFE;
   endfunction

endpackage

// File: rtl/instr_fetch_ext_cnt.sv
// Combinational extension-word counter: from an opcode word, decide whether
// source and/or destination extension words follow it.
module instr_fetch_ext_cnt
   import instr_fetch_pkg::*;
(
   input  logic [15:0] ir,
   output logic [1:0]  n_ext,
   output logic        src_ext,
   output logic        dst_ext
);

   ifu_fmt_t   fmt_s;
   logic       has_src_s;
   logic [3:0] rs_s;
   logic [1:0] as_s;
   logic       cg_s;
   logic       src_mode_s;

   // Classify operand fields and evaluate the extension rules.
   always_comb begin
      fmt_s      = ifu_fmt(ir);
      as_s       = ir[5:4];
      has_src_s  = 1'b0;
      rs_s       = 4'd0;
      dst_ext    = 1'b0;
      src_mode_s = 1'b0;
      case (fmt_s)
         FMT_I: begin
            has_src_s = 1'b1;
            rs_s      = ir[11:8];
            dst_ext   = ir[7];
         end
         FMT_II: begin
            has_src_s = 1'b1;
            rs_s      = ir[3:0];
         end
         default: begin
            has_src_s = 1'b0;
            rs_s      = 4'd0;
            dst_ext   = 1'b0;
         end
      endcase
      // R3 in any mode and R2 in the indirect modes are constant generators.
      cg_s = (rs_s == REG_CG) || ((rs_s == REG_SR) && as_s[1]);
      case (as_s)
         AS_IDX:  src_mode_s = !cg_s;
         AS_INC:  src_mode_s = (rs_s == REG_PC);
         AS_REG:  src_mode_s = 1'b0;
         AS_IND:  src_mode_s = 1'b0;
         default: src_mode_s = 1'b0;
      endcase
      src_ext = has_src_s && src_mode_s;
      n_ext   = {1'b0, src_ext} + {1'b0, dst_ext};
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads the reset vector, gathers an opcode
// plus its extension words and hands them to the decoder. IFU_PREFETCH_EN adds a
// one-entry opcode prefetch buffer used while the decoder stalls.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [15:0] RESET_VEC_ADDR = DEF_RESET_VEC
)(
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] rom_addr,
   output logic        rom_rd,
   input  logic [15:0] rom_rdata,
   input  logic        br_valid,
   input  logic [15:0] br_target,
   input  logic        dec_ready,
   output logic        ir_valid,
   output logic [15:0] ir,
   output logic [15:0] ext_src,
   output logic [15:0] ext_dst,
   output logic [15:0] ir_pc,
   output logic [15:0] pc_out
);

   ifu_state_t  state_r;
   ifu_state_t  next_state_s;
   logic [15:0] pc_r;
   logic [15:0] ir_r;
   logic [15:0] ext_src_r;
   logic [15:0] ext_dst_r;
   logic [15:0] ir_pc_r;
   logic        ir_valid_r;

   logic [15:0] rom_addr_s;
   logic        rom_rd_s;
   logic [15:0] dec_word_s;
   logic [1:0]  n_ext_s;
   logic        src_ext_s;
   logic        dst_ext_s;

   logic        ld_vec_s;
   logic        ld_br_s;
   logic        ld_op_s;
   logic        ld_ext1_s;
   logic        ld_ext2_s;
   logic        pc_inc_s;

`ifdef IFU_PREFETCH_EN
   logic [15:0] pf_word_r;
   logic [15:0] pf_pc_r;
   logic        pf_valid_r;
   logic        pf_fill_s;
   logic        pf_take_s;
`endif

   // Select which word the extension counter inspects this cycle.
   always_comb begin
      dec_word_s = ir_r;
      case (state_r)
         S_OP:    dec_word_s = rom_rdata;
`ifdef IFU_PREFETCH_EN
         S_HOLD:  dec_word_s = pf_valid_r ? pf_word_r : ir_r;
`endif
         default: dec_word_s = ir_r;
      endcase
   end

   instr_fetch_ext_cnt u_ext_cnt (
      .ir      (dec_word_s),
      .n_ext   (n_ext_s),
      .src_ext (src_ext_s),
      .dst_ext (dst_ext_s)
   );

   // Next-state, ROM interface and datapath load strobes.
   always_comb begin
      next_state_s = state_r;
      rom_addr_s   = pc_r;
      rom_rd_s     = 1'b0;
      ld_vec_s     = 1'b0;
      ld_br_s      = 1'b0;
      ld_op_s      = 1'b0;
      ld_ext1_s    = 1'b0;
      ld_ext2_s    = 1'b0;
`ifdef IFU_PREFETCH_EN
      pf_fill_s    = 1'b0;
      pf_take_s    = 1'b0;
`endif
      case (state_r)
         S_VEC: begin
            rom_addr_s   = RESET_VEC_ADDR;
            ld_vec_s     = 1'b1;
            next_state_s = S_OP;
         end
         S_OP: begin
            rom_rd_s = 1'b1;
            if (br_valid) begin
               ld_br_s      = 1'b1;
               next_state_s = S_OP;
            end else begin
               ld_op_s      = 1'b1;
               next_state_s = (n_ext_s == 2'd0) ? S_HOLD : S_EXT1;
            end
         end
         S_EXT1: begin
            rom_rd_s = 1'b1;
            if (br_valid) begin
               ld_br_s      = 1'b1;
               next_state_s = S_OP;
            end else begin
               ld_ext1_s    = 1'b1;
               next_state_s = (n_ext_s == 2'd2) ? S_EXT2 : S_HOLD;
            end
         end
         S_EXT2: begin
            rom_rd_s = 1'b1;
            if (br_valid) begin
               ld_br_s      = 1'b1;
               next_state_s = S_OP;
            end else begin
               ld_ext2_s    = 1'b1;
               next_state_s = S_HOLD;
            end
         end
         S_HOLD: begin
            if (br_valid) begin
               ld_br_s      = 1'b1;
               next_state_s = S_OP;
            end else if (dec_ready) begin
`ifdef IFU_PREFETCH_EN
               if (pf_valid_r) begin
                  pf_take_s    = 1'b1;
                  next_state_s = (n_ext_s == 2'd0) ? S_HOLD : S_EXT1;
               end else begin
                  next_state_s = S_OP;
               end
`else
               next_state_s = S_OP;
`endif
            end else begin
`ifdef IFU_PREFETCH_EN
               if (!pf_valid_r) begin
                  rom_rd_s  = 1'b1;
                  pf_fill_s = 1'b1;
               end else begin
                  pf_fill_s = 1'b0;
               end
`endif
               next_state_s = S_HOLD;
            end
         end
         default: begin
            next_state_s = S_VEC;
         end
      endcase
`ifdef IFU_PREFETCH_EN
      pc_inc_s = ld_op_s || ld_ext1_s || ld_ext2_s || pf_fill_s;
`else
      pc_inc_s = ld_op_s || ld_ext1_s || ld_ext2_s;
`endif
   end

   // Sequencer state and the instruction-valid flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= S_VEC;
         ir_valid_r <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         ir_valid_r <= (next_state_s == S_HOLD);
      end
   end

   // PC, opcode and extension-word registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r      <= 16'h0000;
         ir_r      <= 16'h0000;
         ext_src_r <= 16'h0000;
         ext_dst_r <= 16'h0000;
         ir_pc_r   <= 16'h0000;
      end else begin
         if (ld_vec_s) begin
            pc_r <= word_align(rom_rdata);
         end else if (ld_br_s) begin
            pc_r <= word_align(br_target);
         end else if (pc_inc_s) begin
            pc_r <= pc_r + 16'd2;
         end else begin
            pc_r <= pc_r;
         end

         if (ld_op_s) begin
            ir_r      <= rom_rdata;
            ir_pc_r   <= pc_r;
            ext_src_r <= 16'h0000;
            ext_dst_r <= 16'h0000;
`ifdef IFU_PREFETCH_EN
         end else if (pf_take_s) begin
            ir_r      <= pf_word_r;
            ir_pc_r   <= pf_pc_r;
            ext_src_r <= 16'h0000;
            ext_dst_r <= 16'h0000;
`endif
         end else if (ld_ext1_s) begin
            // The first extension word belongs to the source whenever it has one.
            if (src_ext_s) begin
               ext_src_r <= rom_rdata;
            end else if (dst_ext_s) begin
               ext_dst_r <= rom_rdata;
            end else begin
               ext_dst_r <= ext_dst_r;
            end
         end else if (ld_ext2_s) begin
            ext_dst_r <= rom_rdata;
         end else begin
            ir_r <= ir_r;
         end
      end
   end

`ifdef IFU_PREFETCH_EN
   // One-entry opcode prefetch buffer, filled while the decoder stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pf_word_r  <= 16'h0000;
         pf_pc_r    <= 16'h0000;
         pf_valid_r <= 1'b0;
      end else if (ld_br_s) begin
         pf_valid_r <= 1'b0;
      end else if (pf_fill_s) begin
         pf_word_r  <= rom_rdata;
         pf_pc_r    <= pc_r;
         pf_valid_r <= 1'b1;
      end else if (pf_take_s) begin
         pf_valid_r <= 1'b0;
      end else begin
         pf_valid_r <= pf_valid_r;
      end
   end
`endif

   assign rom_addr = rom_addr_s;
   assign rom_rd   = rom_rd_s;
   assign ir_valid = ir_valid_r;
   assign ir       = ir_r;
   assign ext_src  = ext_src_r;
   assign ext_dst  = ext_dst_r;
   assign ir_pc    = ir_pc_r;
   assign pc_out   = pc_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed program run against a ROM image, with an
// instruction-level model checking every delivered instruction.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] rom_addr;
   logic        rom_rd;
   logic [15:0] rom_rdata;
   logic        br_valid;
   logic [15:0] br_target;
   logic        dec_ready;
   logic        ir_valid;
   logic [15:0] ir;
   logic [15:0] ext_src;
   logic [15:0] ext_dst;
   logic [15:0] ir_pc;
   logic [15:0] pc_out;

   logic [15:0] rom [0:32767];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   assign rom_rdata = rom[rom_addr[15:1]];

   instr_fetch dut (
      .clk       (clk),
      .rst       (rst),
      .rom_addr  (rom_addr),
      .rom_rd    (rom_rd),
      .rom_rdata (rom_rdata),
      .br_valid  (br_valid),
      .br_target (br_target),
      .dec_ready (dec_ready),
      .ir_valid  (ir_valid),
      .ir        (ir),
      .ext_src   (ext_src),
      .ext_dst   (ext_dst),
      .ir_pc     (ir_pc),
      .pc_out    (pc_out)
   );

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h want %h", name, got, want);
   endtask

   function automatic logic [15:0] rd(input logic [15:0] a);
      return rom[a[15:1]];
   endfunction

   function automatic bit needs_src(input logic [15:0] w);
      logic [3:0] r;
      logic [1:0] am;
      am = w[5:4];
      if (w[15:12] >= 4'h4) r = w[11:8];
      else if (w[15:10] == 6'b000100) r = w[3:0];
      else return 1'b0;
      if (r == 4'd3) return 1'b0;
      if (am == 2'b01) return 1'b1;
      if (am == 2'b11 && r == 4'd0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit needs_dst(input logic [15:0] w);
      return (w[15:12] >= 4'h4) && w[7];
   endfunction

   // Instruction-level model: expected next opcode address, advanced on consume/redirect.
   logic [15:0] m_pc;
   bit          m_vec;
   always @(negedge clk) begin
      logic [15:0] w, a1, a2;
      bit s, d;
      if (rst) begin
         m_vec = 1'b1;
         m_pc  = rd(16'hFFFE) & 16'hFFFE;
      end else if (m_vec) begin
         m_vec = 1'b0;
      end else begin
         w  = rd(m_pc);
         s  = needs_src(w);
         d  = needs_dst(w);
         a1 = m_pc + 16'd2;
         a2 = s ? (m_pc + 16'd4) : (m_pc + 16'd2);
         if (ir_valid) begin
            chk("model ir", ir, w);
            chk("model ir_pc", ir_pc, m_pc);
            chk("model ext_src", ext_src, s ? rd(a1) : 16'h0000);
            chk("model ext_dst", ext_dst, d ? rd(a2) : 16'h0000);
         end
         if (br_valid) m_pc = br_target & 16'hFFFE;
         else if (ir_valid && dec_ready) m_pc = m_pc + 16'd2 + (s ? 16'd2 : 16'd0) + (d ? 16'd2 : 16'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, input int want);
      int n = 0;
      bit got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         n++;
         if (ir_valid) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) $display("FAIL %s: ir_valid never rose within 10 cycles", name);
      chk(name, got ? 16'(n) : 16'hFFFF, 16'(want));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic want_rd;
      for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
      rom[16'h4400 >> 1] = 16'h4405;
      rom[16'h4402 >> 1] = 16'h40B2;
      rom[16'h4404 >> 1] = 16'h1234;
      rom[16'h4406 >> 1] = 16'h0200;
      rom[16'h4408 >> 1] = 16'h4315;
      rom[16'h440A >> 1] = 16'h4617;
      rom[16'h440C >> 1] = 16'h0004;
      rom[16'h440E >> 1] = 16'h40B2;
      rom[16'h4410 >> 1] = 16'hAAAA;
      rom[16'h4412 >> 1] = 16'hBBBB;
      rom[16'h4500 >> 1] = 16'h4617;
      rom[16'h4502 >> 1] = 16'h0008;
      rom[16'hFFFC >> 1] = 16'h4617;
      rom[16'hFFFE >> 1] = 16'h4400;
      rom[16'h0000 >> 1] = 16'h4405;
      rom[16'h0002 >> 1] = 16'h40B2;
      rom[16'h0004 >> 1] = 16'h1111;
      rom[16'h0006 >> 1] = 16'h2222;

      rst = 1'b1; br_valid = 1'b0; br_target = 16'h0000; dec_ready = 1'b1;
      step(); step();
      chk("reset rom_addr", rom_addr, 16'hFFFE);
      chk("reset rom_rd", {15'd0, rom_rd}, 16'h0000);
      chk("reset ir_valid", {15'd0, ir_valid}, 16'h0000);
      chk("reset pc_out", pc_out, 16'h0000);
      chk("reset ir", ir, 16'h0000);
      chk("reset ir_pc", ir_pc, 16'h0000);

      rst = 1'b0;
      #1;
      chk("vector rom_addr", rom_addr, 16'hFFFE);
      step();
      chk("first op rom_addr", rom_addr, 16'h4400);
      chk("first op rom_rd", {15'd0, rom_rd}, 16'h0001);
      chk("first op ir_valid", {15'd0, ir_valid}, 16'h0000);
      step();
      chk("mov r4r5 ir_valid", {15'd0, ir_valid}, 16'h0001);
      chk("mov r4r5 ir", ir, 16'h4405);
      chk("mov r4r5 ir_pc", ir_pc, 16'h4400);
      chk("mov r4r5 pc_out", pc_out, 16'h4402);
      chk("mov r4r5 ext_src", ext_src, 16'h0000);

      wait_valid("lat 40B2", 4);
      chk("imm abs ir", ir, 16'h40B2);
      chk("imm abs ext_src", ext_src, 16'h1234);
      chk("imm abs ext_dst", ext_dst, 16'h0200);
      chk("imm abs pc_out", pc_out, 16'h4408);

      wait_valid("lat cg", 2);
      chk("cg ir", ir, 16'h4315);
      chk("cg ext_src", ext_src, 16'h0000);

      wait_valid("lat idx", 3);
      chk("idx ext_src", ext_src, 16'h0004);
      chk("idx ext_dst", ext_dst, 16'h0000);
      chk("idx pc_out", pc_out, 16'h440E);

      step();
      step();
      chk("ext1 rom_addr", rom_addr, 16'h4410);
      br_valid = 1'b1; br_target = 16'h4501;
      step();
      br_valid = 1'b0;
      chk("redirect rom_addr", rom_addr, 16'h4500);
      chk("redirect ir_valid", {15'd0, ir_valid}, 16'h0000);
      wait_valid("lat after redirect", 2);
      chk("redirect ir", ir, 16'h4617);
      chk("redirect ext_src", ext_src, 16'h0008);
      chk("redirect ext_dst", ext_dst, 16'h0000);
      chk("redirect ir_pc", ir_pc, 16'h4500);

      br_valid = 1'b1; br_target = 16'hFFFD;
      step();
      br_valid = 1'b0;
      chk("hold redirect rom_addr", rom_addr, 16'hFFFC);
      chk("hold redirect ir_valid", {15'd0, ir_valid}, 16'h0000);
      wait_valid("lat wrap", 2);
      chk("wrap ext_src", ext_src, 16'h4400);
      chk("wrap pc_out", pc_out, 16'h0000);
      chk("wrap ir_pc", ir_pc, 16'hFFFC);
      wait_valid("lat at zero", 2);
      chk("zero ir", ir, 16'h4405);
      chk("zero ir_pc", ir_pc, 16'h0000);
      chk("zero pc_out", pc_out, 16'h0002);

      dec_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
`ifdef IFU_PREFETCH_EN
         want_rd = (i == 0);
`else
         want_rd = 1'b0;
`endif
         chk("stall rom_rd", {15'd0, rom_rd}, {15'd0, want_rd});
         chk("stall ir_valid", {15'd0, ir_valid}, 16'h0001);
         chk("stall ir", ir, 16'h4405);
         step();
      end
      dec_ready = 1'b1;

      step();
      step();
      rst = 1'b1;
      #1;
      chk("mid rst ir_valid", {15'd0, ir_valid}, 16'h0000);
      chk("mid rst rom_addr", rom_addr, 16'hFFFE);
      chk("mid rst pc_out", pc_out, 16'h0000);
      step();
      rst = 1'b0; br_valid = 1'b1; br_target = 16'h1234;
      #1;
      chk("revector rom_addr", rom_addr, 16'hFFFE);
      step();
      br_valid = 1'b0;
      chk("vec ignores br", rom_addr, 16'h4400);
      wait_valid("lat after reset", 1);
      chk("after reset ir", ir, 16'h4405);
      chk("after reset ir_pc", ir_pc, 16'h4400);
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
